my_pulse_stretcher: RTL and testbench

Output-side counterpart of the team's input debouncer: it drives a clean, timed level onto an external pin instead of filtering a noisy one.
- Accepts single-cycle event strobes from internal logic.
- Emits one pulse per event, each with a guaranteed minimum high time and minimum low gap, so slow external loads (LEDs, relays, opto-couplers) see every event.
- Events arriving while a pulse is in progress are queued in a saturating counter and replayed in order.

---
 rtl/my_pulse_pkg.sv | 17 +
 rtl/my_down_counter.sv | 23 ++
 rtl/my_pulse_stretcher.sv | 110 +++++++++++
 tb/tb_my_pulse_stretcher.sv | 130 +++++++++++++
 4 files changed

// File: rtl/my_pulse_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and the
// elaboration-time width check for the pulse timer.
package my_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // True when value is representable in an unsigned field of the given width.
  function automatic bit fits_width(input int unsigned value, input int unsigned width);
    if (width >= 32) return 1'b1;
    return longint'(value) < (longint'(1) << width);
  endfunction

endpackage

// File: rtl/my_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero when told to
// decrement so an idle timer never wraps.
module my_down_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             synch_reset,
  input  logic             ctrl_load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ctrl_decr,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (synch_reset)              count <= '0;
    else if (ctrl_load)           count <= load_value;
    else if (ctrl_decr && !zero)  count <= count - 1'b1;
  end

endmodule

// File: rtl/my_pulse_stretcher.sv
// Turns single-cycle event strobes into pulses with a guaranteed high time
// and low gap; events seen during a pulse are queued and replayed in order.
module my_pulse_stretcher
  import my_pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int CNT_WIDTH   = 20,
  parameter int PEND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  synch_reset,
  input  logic                  event_input,
  output logic                  signal_output,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending_count,
  output logic                  overflow
);

  if (HIGH_CYCLES < 1 || GAP_CYCLES < 1 ||
      !fits_width(HIGH_CYCLES - 1, CNT_WIDTH) ||
      !fits_width(GAP_CYCLES - 1, CNT_WIDTH)) begin : g_bad_params
    $error("my_pulse_stretcher: HIGH/GAP_CYCLES must be >=1 and fit CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0]  HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

  state_t                state;
  logic                  t_load, t_decr, t_zero;
  logic [CNT_WIDTH-1:0]  t_value, timer;
  logic                  ev_queue, replay;

  my_down_counter #(.WIDTH(CNT_WIDTH)) u_timer (
    .clk        (clk),
    .synch_reset(synch_reset),
    .ctrl_load  (t_load),
    .load_value (t_value),
    .ctrl_decr  (t_decr),
    .count      (timer),
    .zero       (t_zero)
  );

  // The timer is reloaded on every state entry, otherwise it free-runs down.
  always_comb begin
    t_load   = 1'b0;
    t_value  = HIGH_LOAD;
    replay   = (state == ST_GAP) && t_zero && (pending_count != '0);
    ev_queue = event_input && (state != ST_IDLE);
    case (state)
      ST_IDLE: t_load = event_input;
      ST_HIGH: begin
        t_load  = t_zero;
        t_value = GAP_LOAD;
      end
      ST_GAP:  t_load = replay;
      default: t_load = 1'b0;
    endcase
    t_decr = (state != ST_IDLE) && !t_load;
  end

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      state         <= ST_IDLE;
      signal_output <= 1'b0;
      busy          <= 1'b0;
      pending_count <= '0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (event_input) begin
          state         <= ST_HIGH;
          signal_output <= 1'b1;
          busy          <= 1'b1;
        end
        ST_HIGH: if (t_zero) begin
          state         <= ST_GAP;
          signal_output <= 1'b0;
        end
        ST_GAP: if (t_zero) begin
          if (pending_count != '0) begin
            state         <= ST_HIGH;
            signal_output <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          signal_output <= 1'b0;
          busy          <= 1'b0;
        end
      endcase

      // A new event and a replay on the same edge cancel out, even when full.
      if (ev_queue && !replay) begin
        if (pending_count == PEND_MAX) overflow <= 1'b1;
        else                           pending_count <= pending_count + 1'b1;
      end else if (replay && !ev_queue) begin
        pending_count <= pending_count - 1'b1;
      end
    end
  end

  a_idle_timer_zero: assert property (@(posedge clk) disable iff (synch_reset)
    (state == ST_IDLE) |-> (timer == '0));

endmodule

// File: tb/tb_my_pulse_stretcher.sv
// Vector-table bench: each row is a per-edge waveform (one char per clock edge)
// of inputs and expected outputs; expectations are queued at drive time.
module tb_my_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, ev_a = 1'b0, rst_b = 1'b1, ev_b = 1'b0;
  logic       sig_a, busy_a, ovf_a, sig_b, busy_b, ovf_b;
  logic [1:0] pend_a, pend_b;

  always #5 clk = ~clk;

  my_pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(3), .CNT_WIDTH(4), .PEND_WIDTH(2)) dut_a (
    .clk(clk), .synch_reset(rst_a), .event_input(ev_a),
    .signal_output(sig_a), .busy(busy_a), .pending_count(pend_a), .overflow(ovf_a)
  );

  my_pulse_stretcher #(.HIGH_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(4), .PEND_WIDTH(2)) dut_b (
    .clk(clk), .synch_reset(rst_b), .event_input(ev_b),
    .signal_output(sig_b), .busy(busy_b), .pending_count(pend_b), .overflow(ovf_b)
  );

  typedef struct {
    string name;
    bit    sel;
    string rst, ev, sig, busy, pend, ovf;
  } vec_t;

  typedef struct {
    string name;
    int    pos;
    bit    sel;
    int    sig, busy, pend, ovf;
  } exp_t;

  vec_t tests[7];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic string r(string c, int n);
    string s = "";
    for (int k = 0; k < n; k++) s = {s, c};
    return s;
  endfunction

  function automatic vec_t mk(string name, bit sel, string rst, string ev, string sig,
                              string busy, string pend, string ovf);
    vec_t v;
    v.name = name; v.sel = sel; v.rst = rst; v.ev = ev;
    v.sig = sig; v.busy = busy; v.pend = pend; v.ovf = ovf;
    return v;
  endfunction

  function automatic int ch(string s, int i);
    return int'(s[i]) - 48;
  endfunction

  task automatic check(string name, int pos, string field, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d %s: got %0d expected %0d", name, pos, field, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    tests[0] = mk("reset", 0, "110000", "100000", r("0",6), r("0",6), r("0",6), r("0",6));
    tests[1] = mk("single", 0, {"11", r("0",10)}, {r("0",3), "1", r("0",8)},
                  {r("0",3), r("1",4), r("0",5)}, {r("0",3), r("1",7), r("0",2)},
                  r("0",12), r("0",12));
    tests[2] = mk("three", 0, {"11", r("0",24)}, {"0001011", r("0",19)},
                  {r("0",3), r("1",4), r("0",3), r("1",4), r("0",3), r("1",4), r("0",5)},
                  {r("0",3), r("1",21), r("0",2)},
                  {r("0",5), "1", r("2",4), r("1",7), r("0",9)}, r("0",26));
    tests[3] = mk("saturate", 0, {"11", r("0",31)}, {r("0",3), r("1",6), r("0",24)},
                  {r("0",3), r("1",4), r("0",3), r("1",4), r("0",3), r("1",4), r("0",3),
                   r("1",4), r("0",5)},
                  {r("0",3), r("1",28), r("0",2)},
                  {r("0",4), "1", "2", r("3",4), r("2",7), r("1",7), r("0",9)},
                  {r("0",7), r("1",26)});
    tests[4] = mk("gap_end_event", 0, {"11", r("0",24)}, {r("0",3), "11", r("0",5), "1", r("0",15)},
                  {r("0",3), r("1",4), r("0",3), r("1",4), r("0",3), r("1",4), r("0",5)},
                  {r("0",3), r("1",21), r("0",2)},
                  {r("0",4), r("1",13), r("0",9)}, r("0",26));
    tests[5] = mk("mid_reset", 0, {"11", r("0",4), "1", r("0",10)},
                  {r("0",3), "111", r("0",2), "1", r("0",8)},
                  {r("0",3), r("1",3), r("0",2), r("1",4), r("0",5)},
                  {r("0",3), r("1",3), r("0",2), r("1",7), r("0",2)},
                  {r("0",4), "12", r("0",11)}, r("0",17));
    tests[6] = mk("min_params", 1, {"11", r("0",9)}, {r("0",3), r("1",3), r("0",5)},
                  {r("0",3), "10101", r("0",3)}, {r("0",3), r("1",6), r("0",2)},
                  {r("0",4), r("1",3), r("0",4)}, r("0",11));

    for (int t = 0; t < 7; t++) begin
      n = tests[t].sig.len();
      for (int i = 0; i < n; i++) begin
        if (tests[t].sel) begin
          rst_b = tests[t].rst[i] == "1"; ev_b = tests[t].ev[i] == "1";
          rst_a = 1'b1;                   ev_a = 1'b0;
        end else begin
          rst_a = tests[t].rst[i] == "1"; ev_a = tests[t].ev[i] == "1";
          rst_b = 1'b1;                   ev_b = 1'b0;
        end
        sb.push_back('{name: tests[t].name, pos: i, sel: tests[t].sel,
                       sig: ch(tests[t].sig, i), busy: ch(tests[t].busy, i),
                       pend: ch(tests[t].pend, i), ovf: ch(tests[t].ovf, i)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
          check(e.name, e.pos, "signal_output", int'(sig_b), e.sig);
          check(e.name, e.pos, "busy", int'(busy_b), e.busy);
          check(e.name, e.pos, "pending_count", int'(pend_b), e.pend);
          check(e.name, e.pos, "overflow", int'(ovf_b), e.ovf);
        end else begin
          check(e.name, e.pos, "signal_output", int'(sig_a), e.sig);
          check(e.name, e.pos, "busy", int'(busy_a), e.busy);
          check(e.name, e.pos, "pending_count", int'(pend_a), e.pend);
          check(e.name, e.pos, "overflow", int'(ovf_a), e.ovf);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
